// File: rtl/const.sv
// Shared slot-bus constants: register indices, CTRL/STATUS bit positions and
// the slot handshake state.
package mmio_pkg;
  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_COUNT_LO = 4'd2;
  localparam logic [3:0] REG_COUNT_HI = 4'd3;
  localparam logic [3:0] REG_CMP_LO   = 4'd4;
  localparam logic [3:0] REG_CMP_HI   = 4'd5;
  localparam logic [3:0] REG_PRESCALE = 4'd6;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_AR     = 3;
  localparam int STAT_MATCH  = 0;
  localparam int STAT_RUN    = 1;

  typedef enum logic {S_IDLE, S_RESP} slot_state_e;
endpackage

// File: rtl/mmio_prescaler.sv
// Prescaler: counts up to the programmed value and emits a one-cycle tick,
// then wraps to 0. Sync clear wins over counting.
module mmio_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)    cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= '0;
    else if (en)    cnt <= cnt + PRESCALE_W'(1);
  end
endmodule

// File: rtl/mmio_timer_core.sv
// Slot-0 MMIO timer: single-cycle slot command decode, register file, 64-bit
// counter with compare/auto-reload, and a level interrupt on match.
module mmio_timer_core
  import mmio_pkg::*;
#(
  parameter int                    PRESCALE_W   = 16,
  parameter logic [PRESCALE_W-1:0] RST_PRESCALE = '0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        wr_done,
  output logic        rd_done,
  output logic        idle,
  output logic        slave_error,
  output logic        decode_error,
  output logic        irq
);
  slot_state_e state, state_nxt;

  logic                  ctrl_en, ctrl_irq_en, ctrl_ar, match;
  logic [63:0]           counter, cmp;
  logic [31:0]           snap, rd_val;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tick, tick_eff;
  logic                  sel, both, acc_wr, acc_rd, mapped, wr_illegal;
  logic                  wr_ok, rd_ok, clr_wr, w1c;

  assign idle   = (state == S_IDLE);
  assign sel    = cs && idle && (read || write);
  assign both   = read && write;
  assign acc_wr = sel && write && !read;
  assign acc_rd = sel && read && !write;
  assign mapped = (reg_addr <= REG_PRESCALE);

  assign wr_illegal = acc_wr && ((reg_addr == REG_COUNT_LO) || (reg_addr == REG_COUNT_HI) ||
                                 ((reg_addr == REG_STATUS) && (wr_data == 32'h2)));
  assign wr_ok    = acc_wr && mapped && !wr_illegal;
  assign rd_ok    = acc_rd && mapped;
  assign clr_wr   = wr_ok && (reg_addr == REG_CTRL) && wr_data[CTRL_CLR];
  assign w1c      = wr_ok && (reg_addr == REG_STATUS) && wr_data[STAT_MATCH];
  // A clear in the same cycle discards the tick entirely.
  assign tick_eff = tick && !clr_wr;
  assign irq      = match && ctrl_irq_en;

  mmio_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .arst_n   (arst_n),
    .en       (ctrl_en),
    .clr      (clr_wr),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (sel) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      REG_CTRL:     rd_val = {28'b0, ctrl_ar, ctrl_irq_en, 1'b0, ctrl_en};
      REG_STATUS:   rd_val = {30'b0, ctrl_en, match};
      REG_COUNT_LO: rd_val = counter[31:0];
      REG_COUNT_HI: rd_val = snap;
      REG_CMP_LO:   rd_val = cmp[31:0];
      REG_CMP_HI:   rd_val = cmp[63:32];
      REG_PRESCALE: rd_val = 32'(prescale);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_IDLE;
      rd_data      <= '0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      slave_error  <= 1'b0;
      decode_error <= 1'b0;
      snap         <= '0;
    end else begin
      state        <= state_nxt;
      wr_done      <= wr_ok;
      rd_done      <= rd_ok;
      slave_error  <= sel && (both || wr_illegal);
      decode_error <= sel && !both && !mapped;
      if (rd_ok) rd_data <= rd_val;
      if (rd_ok && (reg_addr == REG_COUNT_LO)) snap <= counter[63:32];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_ar     <= 1'b0;
      cmp         <= '1;
      prescale    <= RST_PRESCALE;
    end else if (wr_ok) begin
      case (reg_addr)
        REG_CTRL: begin
          ctrl_en     <= wr_data[CTRL_EN];
          ctrl_irq_en <= wr_data[CTRL_IRQ_EN];
          ctrl_ar     <= wr_data[CTRL_AR];
        end
        REG_CMP_LO:   cmp[31:0]  <= wr_data;
        REG_CMP_HI:   cmp[63:32] <= wr_data;
        REG_PRESCALE: prescale   <= wr_data[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  // Match compares the pre-update count; setting it beats a same-cycle W1C.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      counter <= '0;
      match   <= 1'b0;
    end else begin
      if (clr_wr)        counter <= '0;
      else if (tick_eff) counter <= (ctrl_ar && (counter == cmp)) ? 64'd0 : counter + 64'd1;
      if (tick_eff && (counter == cmp)) match <= 1'b1;
      else if (w1c)                     match <= 1'b0;
    end
  end
endmodule
